// File: rtl/alu_pkg.sv
// Shared opcode encodings and execute-unit FSM states.
// Pure declarations, no timing.
// Used by the execute unit and the instruction sequencer.
package alu_pkg;

    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_EXCH = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes new A/B, carry and zero for one instruction.
// Zero latency.
// SHR with a nonzero amount is only flagged as multicycle; the caller does the shifting.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] new_a,
    output logic [WIDTH-1:0] new_b,
    output logic             carry,
    output logic             zero,
    output logic             multicycle
);

    // Opcode decode; unused outputs default to pass-through so MOV/EXCH share the write path
    always_comb begin
        new_a      = a;
        new_b      = b;
        carry      = 1'b0;
        multicycle = 1'b0;
        case (op)
            OP_ADD:  {carry, new_a} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, new_a} = {1'b0, a} - {1'b0, b};
            OP_OR:   new_a = a | b;
            OP_AND:  new_a = a & b;
            OP_XOR:  new_a = a ^ b;
            OP_SHR:  multicycle = (b[SW-1:0] != '0);
            OP_MOV:  new_b = a;
            OP_EXCH: begin
                new_a = b;
                new_b = a;
            end
            default: new_a = a;
        endcase
    end

    assign zero = (new_a == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Register-file execute unit: single-cycle ALU ops plus bit-serial SHR.
// Single-cycle ops: done one cycle after accept; SHR by n: done n cycles after accept.
// in_ready is low while a shift is in progress; loads are dropped then.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    localparam int IW    = $clog2(NREGS),
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [IW-1:0]    a_idx,
    input  logic [IW-1:0]    b_idx,
    input  logic             ld_en,
    input  logic [IW-1:0]    ld_idx,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_val, b_val;
    logic [WIDTH-1:0] core_new_a, core_new_b;
    logic             core_carry, core_zero, core_multi;
    logic             accept, flag_we;
    logic [WIDTH-1:0] shift_val, shift_next;
    logic [SW-1:0]    cnt_q;
    logic [IW-1:0]    shift_idx;

    assign a_val      = regs[a_idx];
    assign b_val      = regs[b_idx];
    assign rd_data    = regs[rd_idx];
    assign in_ready   = (state_q == S_IDLE);
    assign accept     = in_valid & in_ready;
    assign flag_we    = (op != OP_MOV) && (op != OP_EXCH);
    assign shift_next = shift_val >> 1;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a          (a_val),
        .b          (b_val),
        .op         (op),
        .new_a      (core_new_a),
        .new_b      (core_new_b),
        .carry      (core_carry),
        .zero       (core_zero),
        .multicycle (core_multi)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: enter SHIFT for a nonzero shift, leave on the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && core_multi) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == SW'(1))      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register file, flags, shifter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            done      <= 1'b0;
            shift_val <= '0;
            cnt_q     <= '0;
            shift_idx <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (core_multi) begin
                    shift_val <= a_val;
                    cnt_q     <= b_val[SW-1:0];
                    shift_idx <= a_idx;
                    // a 1-bit shift retires after its only SHIFT cycle
                    done      <= (b_val[SW-1:0] == SW'(1));
                end else begin
                    // B first so that A's result wins when a_idx == b_idx
                    regs[b_idx] <= core_new_b;
                    regs[a_idx] <= core_new_a;
                    if (flag_we) begin
                        flag_c <= core_carry;
                        flag_z <= core_zero;
                    end
                    done <= 1'b1;
                end
            end else if ((state_q == S_IDLE) && ld_en) begin
                regs[ld_idx] <= ld_data;
            end
            if (state_q == S_SHIFT) begin
                shift_val <= shift_next;
                cnt_q     <= cnt_q - SW'(1);
                // done rises in the final SHIFT cycle, together with in_ready still low
                if (cnt_q == SW'(2)) done <= 1'b1;
                if (cnt_q == SW'(1)) begin
                    regs[shift_idx] <= shift_next;
                    flag_c          <= shift_val[0];
                    flag_z          <= (shift_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit with a behavioural reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [1:0]  a_idx = '0, b_idx = '0, ld_idx = '0, rd_idx = '0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_data = '0;
    logic [15:0] rd_data;
    logic        done, flag_c, flag_z;

    alu_exec_unit #(.WIDTH(16), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_idx(a_idx), .b_idx(b_idx), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data), .rd_idx(rd_idx),
        .rd_data(rd_data), .done(done), .flag_c(flag_c), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ready_low = 0;
    bit chk_en = 1'b0;

    // reference model: architectural state as seen after the most recent edge
    logic [15:0] m_regs [4];
    logic        m_c, m_z;
    bit          m_ready, m_done;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_ready", 32'(in_ready), 32'(m_ready));
            cmp("done",     32'(done),     32'(m_done));
            cmp("flag_c",   32'(flag_c),   32'(m_c));
            cmp("flag_z",   32'(flag_z),   32'(m_z));
            cmp("rd_data",  32'(rd_data),  32'(m_regs[rd_idx]));
            if (!in_ready) ready_low++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_done = 1'b0;
        rd_idx = rd_idx + 2'd1;
    endtask

    task automatic peek(input string name, input logic [1:0] idx, input logic [15:0] exp);
        rd_idx = idx;
        #1;
        cmp(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic load(input logic [1:0] idx, input logic [15:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_data = val;
        step();
        ld_en = 1'b0;
        m_regs[idx] = val;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_c = 1'b0; m_z = 1'b0; m_ready = 1'b1; m_done = 1'b0;
    endtask

    task automatic exec(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                        input bit ld_during);
        logic [15:0] va, vb, res;
        int s, amt;
        va = m_regs[a]; vb = m_regs[b]; amt = int'(vb[3:0]);
        in_valid = 1'b1; op = o; a_idx = a; b_idx = b;
        step();
        in_valid = 1'b0;
        if (o == OP_SHR && amt != 0) begin
            m_ready = 1'b0;
            m_done  = (amt == 1);
            if (ld_during) begin
                ld_en = 1'b1; ld_idx = b; ld_data = 16'h7777;
            end
            for (int k = 1; k <= amt; k++) begin
                step();
                ld_en = 1'b0;
                if (k < amt) begin
                    m_done = (k + 1 == amt);
                end else begin
                    res = va >> amt;
                    m_regs[a] = res;
                    m_c = va[amt-1];
                    m_z = (res == 0);
                    m_ready = 1'b1;
                end
            end
        end else begin
            m_done = 1'b1;
            case (o)
                OP_ADD: begin
                    s = int'(va) + int'(vb);
                    res = 16'(s);
                    m_c = (s > 65535); m_z = (res == 0); m_regs[a] = res;
                end
                OP_SUB: begin
                    res = va - vb;
                    m_c = (va < vb); m_z = (res == 0); m_regs[a] = res;
                end
                OP_OR:  begin res = va | vb; m_c = 1'b0; m_z = (res == 0); m_regs[a] = res; end
                OP_AND: begin res = va & vb; m_c = 1'b0; m_z = (res == 0); m_regs[a] = res; end
                OP_XOR: begin res = va ^ vb; m_c = 1'b0; m_z = (res == 0); m_regs[a] = res; end
                OP_SHR: begin m_c = 1'b0; m_z = (va == 0); end
                OP_MOV: m_regs[b] = va;
                default: begin m_regs[a] = vb; m_regs[b] = va; end
            endcase
        end
    endtask

    initial begin
        int base;
        model_reset();
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        cmp("reset_in_ready", 32'(in_ready), 1);
        cmp("reset_done", 32'(done), 0);
        cmp("reset_flag_c", 32'(flag_c), 0);
        cmp("reset_flag_z", 32'(flag_z), 0);
        for (int i = 0; i < 4; i++) peek("reset_reg", 2'(i), 16'h0000);

        // XOR
        load(2'd0, 16'h00F0);
        load(2'd1, 16'h0F0F);
        exec(OP_XOR, 2'd0, 2'd1, 1'b0);
        cmp("xor_done", 32'(done), 1);
        peek("xor_r0", 2'd0, 16'h0FFF);
        cmp("xor_flag_z", 32'(flag_z), 0);
        cmp("xor_flag_c", 32'(flag_c), 0);

        // ADD with carry out, then SUB
        load(2'd0, 16'hFFFF);
        load(2'd1, 16'h0001);
        exec(OP_ADD, 2'd0, 2'd1, 1'b0);
        peek("add_r0", 2'd0, 16'h0000);
        cmp("add_flag_c", 32'(flag_c), 1);
        cmp("add_flag_z", 32'(flag_z), 1);
        exec(OP_SUB, 2'd1, 2'd0, 1'b0);
        peek("sub_r1", 2'd1, 16'h0001);
        cmp("sub_flag_c", 32'(flag_c), 0);

        // SHR by 5, with a load attempted mid-shift
        load(2'd2, 16'h8001);
        load(2'd3, 16'h0005);
        base = ready_low;
        exec(OP_SHR, 2'd2, 2'd3, 1'b1);
        cmp("shr_ready_low_cycles", 32'(ready_low - base), 5);
        peek("shr_r2", 2'd2, 16'h0400);
        peek("shr_r3_load_dropped", 2'd3, 16'h0005);
        cmp("shr_flag_c", 32'(flag_c), 0);

        // set carry, then EXCH and MOV back-to-back must leave flags alone
        load(2'd2, 16'hFFFF);
        load(2'd3, 16'h0002);
        exec(OP_ADD, 2'd2, 2'd3, 1'b0);
        load(2'd0, 16'h1234);
        load(2'd1, 16'hABCD);
        exec(OP_EXCH, 2'd0, 2'd1, 1'b0);
        peek("exch_r0", 2'd0, 16'hABCD);
        peek("exch_r1", 2'd1, 16'h1234);
        exec(OP_MOV, 2'd0, 2'd1, 1'b0);
        peek("mov_r1", 2'd1, 16'hABCD);
        cmp("mov_flag_c_kept", 32'(flag_c), 1);

        // same-register operands
        load(2'd2, 16'h5555);
        exec(OP_SUB, 2'd2, 2'd2, 1'b0);
        peek("subself_r2", 2'd2, 16'h0000);
        cmp("subself_flag_z", 32'(flag_z), 1);
        exec(OP_EXCH, 2'd1, 2'd1, 1'b0);
        cmp("exchself_done", 32'(done), 1);
        peek("exchself_r1", 2'd1, 16'hABCD);
        load(2'd3, 16'h4321);
        exec(OP_ADD, 2'd3, 2'd3, 1'b0);
        peek("addself_r3", 2'd3, 16'h8642);

        // reset during a 12-bit shift
        load(2'd0, 16'h1234);
        load(2'd1, 16'h000C);
        in_valid = 1'b1; op = OP_SHR; a_idx = 2'd0; b_idx = 2'd1;
        step();
        in_valid = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        step();
        cmp("abort_in_ready", 32'(in_ready), 1);
        cmp("abort_done", 32'(done), 0);
        peek("abort_r0", 2'd0, 16'h0000);
        peek("abort_r1", 2'd1, 16'h0000);
        load(2'd0, 16'h0003);
        load(2'd1, 16'h0004);
        exec(OP_ADD, 2'd0, 2'd1, 1'b0);
        peek("post_abort_add", 2'd0, 16'h0007);

        repeat (2) step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
